ssb_host_arbiter: RTL

Arbiter and response router for the shared system bus (SSB) in `ibex_super_system`. It lets several bus hosts share one downstream device port: the debug module SBA host, the Ibex instruction port and the Ibex data port. It replaces the ad-hoc fixed-priority mux with round-robin arbitration, honours device back-pressure, and tracks outstanding transactions so that each `rvalid` is returned to the host that issued it.

---
 rtl/ssb_arb_pkg.sv | 19 +
 rtl/ssb_arb_id_fifo.sv | 58 +++++
 rtl/ssb_host_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ssb_arb_pkg.sv
// rtl/ssb_arb_pkg.sv - shared constants and request attribute type for the SSB host arbiter
package ssb_arb_pkg;

    localparam int SsbAddrW = 32;
    localparam int SsbDataW = 32;
    localparam int SsbBeW   = 4;

    localparam int HostDbg   = 0;
    localparam int HostInstr = 1;
    localparam int HostData  = 2;

    typedef struct packed {
        logic [SsbAddrW-1:0] addr;
        logic                we;
        logic [SsbBeW-1:0]   be;
        logic [SsbDataW-1:0] wdata;
    } ssb_req_t;

endpackage

// File: rtl/ssb_arb_id_fifo.sv
// rtl/ssb_arb_id_fifo.sv - outstanding host-ID FIFO; head is the host owed the next response
module ssb_arb_id_fifo #(
    parameter int Width = 2,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Depth-1:0][Width-1:0] mem;
    logic [PtrW-1:0]             wr_ptr;
    logic [PtrW-1:0]             rd_ptr;
    logic [CntW-1:0]             count;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count == CntW'(Depth));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + PtrW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ssb_host_arbiter.sv
// rtl/ssb_host_arbiter.sv - round-robin SSB host arbiter with in-order response routing (option: SSB_ARB_DBG_PRIO_EN)
module ssb_host_arbiter
    import ssb_arb_pkg::*;
#(
    parameter int NrHosts        = 3,
    parameter int MaxOutstanding = 2
) (
    input  logic                               clk_sys_i,
    input  logic                               rst_sys_ni,
    input  logic [NrHosts-1:0]                 host_req_i,
    input  logic [NrHosts-1:0][SsbAddrW-1:0]   host_addr_i,
    input  logic [NrHosts-1:0]                 host_we_i,
    input  logic [NrHosts-1:0][SsbBeW-1:0]     host_be_i,
    input  logic [NrHosts-1:0][SsbDataW-1:0]   host_wdata_i,
    output logic [NrHosts-1:0]                 host_gnt_o,
    output logic [NrHosts-1:0]                 host_rvalid_o,
    output logic [SsbDataW-1:0]                host_rdata_o,
    output logic                               host_err_o,
    output logic                               dev_req_o,
    output logic [SsbAddrW-1:0]                dev_addr_o,
    output logic                               dev_we_o,
    output logic [SsbBeW-1:0]                  dev_be_o,
    output logic [SsbDataW-1:0]                dev_wdata_o,
    input  logic                               dev_gnt_i,
    input  logic                               dev_rvalid_i,
    input  logic [SsbDataW-1:0]                dev_rdata_i,
    input  logic                               dev_err_i,
    output logic                               err_spurious_o
);

    localparam int IdW = (NrHosts > 1) ? $clog2(NrHosts) : 1;

`ifdef SSB_ARB_DBG_PRIO_EN
    localparam bit DbgPrio = 1'b1;
`else
    localparam bit DbgPrio = 1'b0;
`endif

    logic [IdW-1:0] rr_q;
    logic [IdW-1:0] winner;
    logic [IdW:0]   sum;
    logic [IdW-1:0] idx;
    logic           found;
    logic           handshake;
    logic           fifo_full;
    logic           fifo_empty;
    logic [IdW-1:0] fifo_head;
    logic           resp_pop;
    ssb_req_t       win_req;

    // Search begins one past the last winner; host 0 is excluded from the rotation when it has priority.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        if (DbgPrio && host_req_i[0]) begin
            found = 1'b1;
        end
        for (int k = 1; k <= NrHosts; k++) begin
            sum = {1'b0, rr_q} + (IdW+1)'(k);
            if (sum >= (IdW+1)'(NrHosts)) begin
                sum = sum - (IdW+1)'(NrHosts);
            end
            idx = sum[IdW-1:0];
            if (!found && host_req_i[idx] && !(DbgPrio && idx == '0)) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    assign dev_req_o = (|host_req_i) & ~fifo_full;
    assign handshake = dev_req_o & dev_gnt_i;

    always_comb begin
        win_req = '0;
        if (dev_req_o) begin
            win_req.addr  = host_addr_i[winner];
            win_req.we    = host_we_i[winner];
            win_req.be    = host_be_i[winner];
            win_req.wdata = host_wdata_i[winner];
        end
    end

    assign dev_addr_o  = win_req.addr;
    assign dev_we_o    = win_req.we;
    assign dev_be_o    = win_req.be;
    assign dev_wdata_o = win_req.wdata;

    always_comb begin
        host_gnt_o = '0;
        if (handshake) begin
            host_gnt_o[winner] = 1'b1;
        end
    end

    assign resp_pop = dev_rvalid_i & ~fifo_empty;

    always_comb begin
        host_rvalid_o = '0;
        if (resp_pop) begin
            host_rvalid_o[fifo_head] = 1'b1;
        end
    end

    assign host_rdata_o = dev_rdata_i;
    assign host_err_o   = dev_err_i;

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            rr_q           <= IdW'(NrHosts - 1);
            err_spurious_o <= 1'b0;
        end else begin
            if (handshake && !(DbgPrio && winner == '0)) begin
                rr_q <= winner;
            end
            if (dev_rvalid_i && fifo_empty) begin
                err_spurious_o <= 1'b1;
            end
        end
    end

    ssb_arb_id_fifo #(
        .Width (IdW),
        .Depth (MaxOutstanding)
    ) u_id_fifo (
        .clk       (clk_sys_i),
        .rst_n     (rst_sys_ni),
        .push      (handshake),
        .push_data (winner),
        .pop       (resp_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
